iddr_delay_ctrl: RTL and testbench

// Per-lane input-delay tap controller for multi-lane IDDR receive paths.
// - Accepts tap-adjust commands (INC/DEC by N steps, LOAD absolute value) over a valid/ready handshake.
// - Sequences each command onto one lane's delay element: drop EN_VTC, wait, issue paced CE or LOAD pulses, restore EN_VTC.
// - Keeps a per-lane shadow tap count so training logic can sweep the data eye without reading delay outputs back.

---
 rtl/iddr_delay_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_iddr_delay_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iddr_delay_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iddr_delay_ctrl : per-lane IDELAY tap sequencer with shadow tap counts
// Rev 1.0
// ---------------------------------------------------------------------------
module iddr_delay_ctrl #(
  parameter int LANES       = 4,
  parameter int TAP_WIDTH   = 9,
  parameter int MAX_TAP     = 511,
  parameter int DEFAULT_TAP = 25,
  parameter int VTC_SETTLE  = 10,
  parameter int STEP_SETTLE = 4,
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       idelay_rdy,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [LW-1:0]              cmd_lane,
  input  logic [1:0]                 cmd_op,
  input  logic [TAP_WIDTH-1:0]       cmd_arg,
  output logic                       done,
  output logic                       done_sat,
  output logic                       done_err,
  output logic                       busy,
  output logic [LANES-1:0]           delay_en_vtc,
  output logic [LANES-1:0]           delay_ce,
  output logic                       delay_inc,
  output logic [LANES-1:0]           delay_load,
  output logic [TAP_WIDTH-1:0]       delay_cntvalue,
  output logic [LANES*TAP_WIDTH-1:0] tap_value
);

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  localparam int VS = (VTC_SETTLE < 1) ? 1 : VTC_SETTLE;
  localparam int SS = (STEP_SETTLE < 1) ? 1 : STEP_SETTLE;
  localparam int CW = $clog2(((VS > SS) ? VS : SS) + 1);

  localparam logic [CW-1:0]        VS_INIT = CW'(VS - 1);
  localparam logic [CW-1:0]        SS_INIT = CW'(SS - 1);
  localparam logic [CW-1:0]        CNT_ONE = CW'(1);
  localparam logic [TAP_WIDTH-1:0] TAP_ONE = TAP_WIDTH'(1);
  localparam logic [TAP_WIDTH-1:0] MAX_T   = TAP_WIDTH'(MAX_TAP);
  localparam logic [TAP_WIDTH-1:0] DEF_T   = TAP_WIDTH'(DEFAULT_TAP);
  localparam logic [LW:0]          LANES_W = (LW + 1)'(LANES);

  typedef enum logic [2:0] {
    S_IDLE, S_VTC_OFF, S_STEP, S_LOAD, S_SETTLE, S_VTC_ON
  } state_t;

  state_t               state_q;
  logic [LW-1:0]        lane_q;
  logic [1:0]           op_q;
  logic [TAP_WIDTH-1:0] steps_q;
  logic                 load_sat_q;
  logic [CW-1:0]        cnt_q;
  logic [TAP_WIDTH-1:0] tap_q [LANES];
  logic [LANES-1:0]     en_vtc_q, ce_q, load_q;
  logic                 inc_q, done_q, sat_q, err_q, busy_q;
  logic [TAP_WIDTH-1:0] cntvalue_q;

  logic [TAP_WIDTH-1:0] cur_tap, step_tap, clip_arg;
  logic [LANES-1:0]     lane_oh, cmd_oh;
  logic at_limit, more_steps, active, abort, decide, finish_load;
  logic accept, reject, zero_cmd;

  always_comb begin
    cur_tap = '0;
    lane_oh = '0;
    cmd_oh  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LW'(i)) begin
        cur_tap    = tap_q[i];
        lane_oh[i] = 1'b1;
      end
      if (cmd_lane == LW'(i)) cmd_oh[i] = 1'b1;
    end
  end

  assign at_limit   = (op_q == OP_INC) ? (cur_tap >= MAX_T) : (cur_tap == '0);
  assign more_steps = (steps_q != '0) && !at_limit;
  assign step_tap   = (op_q == OP_INC) ? (cur_tap + TAP_ONE) : (cur_tap - TAP_ONE);
  assign clip_arg   = (cmd_arg > MAX_T) ? MAX_T : cmd_arg;

  assign active = (state_q == S_VTC_OFF) || (state_q == S_STEP) ||
                  (state_q == S_LOAD)    || (state_q == S_SETTLE);
  assign abort  = active && !idelay_rdy;

  // End of a wait window: pick the next step or finish the command.
  assign decide = (((state_q == S_VTC_OFF) || (state_q == S_SETTLE)) &&
                   (cnt_q == '0) && (op_q != OP_LOAD)) ||
                  ((state_q == S_STEP) && (STEP_SETTLE == 0));
  assign finish_load = ((state_q == S_SETTLE) && (cnt_q == '0) && (op_q == OP_LOAD)) ||
                       ((state_q == S_LOAD) && (STEP_SETTLE == 0));

  assign cmd_ready = (state_q == S_IDLE) && idelay_rdy;
  assign accept    = cmd_valid && cmd_ready;
  assign reject    = ({1'b0, cmd_lane} >= LANES_W) || (cmd_op == OP_RSV);
  assign zero_cmd  = (cmd_op != OP_LOAD) && (cmd_arg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lane_q     <= '0;
      op_q       <= OP_INC;
      steps_q    <= '0;
      load_sat_q <= 1'b0;
      cnt_q      <= '0;
      en_vtc_q   <= '1;
      ce_q       <= '0;
      load_q     <= '0;
      inc_q      <= 1'b0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      cntvalue_q <= '0;
      for (int i = 0; i < LANES; i++) tap_q[i] <= DEF_T;
    end else begin
      ce_q   <= '0;
      load_q <= '0;
      inc_q  <= 1'b0;
      done_q <= 1'b0;
      sat_q  <= 1'b0;
      err_q  <= 1'b0;
      if (abort) begin
        state_q  <= S_VTC_ON;
        en_vtc_q <= '1;
        done_q   <= 1'b1;
        err_q    <= 1'b1;
      end else if (decide && more_steps) begin
        state_q <= S_STEP;
        ce_q    <= lane_oh;
        inc_q   <= (op_q == OP_INC);
        steps_q <= steps_q - TAP_ONE;
        for (int i = 0; i < LANES; i++)
          if (lane_oh[i]) tap_q[i] <= step_tap;
      end else if (decide || finish_load) begin
        // Leftover steps at this point mean the lane hit its tap limit.
        state_q  <= S_VTC_ON;
        en_vtc_q <= '1;
        done_q   <= 1'b1;
        sat_q    <= finish_load ? load_sat_q : (steps_q != '0);
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              lane_q  <= cmd_lane;
              op_q    <= cmd_op;
              steps_q <= cmd_arg;
              busy_q  <= 1'b1;
              if (reject) begin
                state_q <= S_VTC_ON;
                done_q  <= 1'b1;
                err_q   <= 1'b1;
              end else if (zero_cmd) begin
                state_q <= S_VTC_ON;
                done_q  <= 1'b1;
              end else begin
                state_q  <= S_VTC_OFF;
                en_vtc_q <= ~cmd_oh;
                cnt_q    <= VS_INIT;
                if (cmd_op == OP_LOAD) begin
                  cntvalue_q <= clip_arg;
                  load_sat_q <= (cmd_arg > MAX_T);
                end
              end
            end
          end
          S_VTC_OFF: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CNT_ONE;
            end else begin
              state_q <= S_LOAD;
              load_q  <= lane_oh;
              for (int i = 0; i < LANES; i++)
                if (lane_oh[i]) tap_q[i] <= cntvalue_q;
            end
          end
          S_STEP, S_LOAD: begin
            state_q <= S_SETTLE;
            cnt_q   <= SS_INIT;
          end
          S_SETTLE: begin
            if (cnt_q != '0) cnt_q <= cnt_q - CNT_ONE;
          end
          S_VTC_ON: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign done           = done_q;
  assign done_sat       = sat_q;
  assign done_err       = err_q;
  assign busy           = busy_q;
  assign delay_en_vtc   = en_vtc_q;
  assign delay_ce       = ce_q;
  assign delay_inc      = inc_q;
  assign delay_load     = load_q;
  assign delay_cntvalue = cntvalue_q;

  for (genvar g = 0; g < LANES; g++) begin : g_tap
    assign tap_value[g*TAP_WIDTH +: TAP_WIDTH] = tap_q[g];
  end

endmodule
`default_nettype wire

// File: tb/tb_iddr_delay_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_iddr_delay_ctrl : table-driven, randomized and corner-case checks
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_iddr_delay_ctrl;

  localparam int LANES = 4;
  localparam int MAXT  = 511;
  localparam int DEFT  = 25;
  localparam int VS    = 10;
  localparam int SS    = 4;

  logic        clk = 1'b0;
  logic        rst_n, idelay_rdy, cmd_valid, cmd_ready;
  logic [1:0]  cmd_lane, cmd_op;
  logic [8:0]  cmd_arg;
  logic        done, done_sat, done_err, busy, inc;
  logic [3:0]  en_vtc, ce, load;
  logic [8:0]  cntv;
  logic [35:0] tapv;

  logic        d2_rdy, d2_valid, d2_ready;
  logic [1:0]  d2_lane, d2_op;
  logic [8:0]  d2_arg;
  logic        d2_done, d2_sat, d2_err, d2_busy, d2_inc;
  logic [2:0]  d2_vtc, d2_ce, d2_load;
  logic [8:0]  d2_cntv;
  logic [26:0] d2_tapv;

  iddr_delay_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .idelay_rdy(idelay_rdy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_lane(cmd_lane),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .done(done), .done_sat(done_sat),
    .done_err(done_err), .busy(busy), .delay_en_vtc(en_vtc), .delay_ce(ce),
    .delay_inc(inc), .delay_load(load), .delay_cntvalue(cntv), .tap_value(tapv)
  );

  // Three lanes and a reduced tap ceiling make lane rejection and LOAD clipping reachable.
  iddr_delay_ctrl #(.LANES(3), .MAX_TAP(300)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .idelay_rdy(d2_rdy),
    .cmd_valid(d2_valid), .cmd_ready(d2_ready), .cmd_lane(d2_lane),
    .cmd_op(d2_op), .cmd_arg(d2_arg), .done(d2_done), .done_sat(d2_sat),
    .done_err(d2_err), .busy(d2_busy), .delay_en_vtc(d2_vtc), .delay_ce(d2_ce),
    .delay_inc(d2_inc), .delay_load(d2_load), .delay_cntvalue(d2_cntv), .tap_value(d2_tapv)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] model_tap [LANES];

  typedef struct {
    int done_c; int n_ce; int n_ld; logic sat; logic err; logic drop; int tap;
  } exp_t;

  typedef struct {
    int lane; int op; int arg; int done_c; int n_ce; int n_ld; logic sat; logic err; int tap;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [35:0] pack_model();
    logic [35:0] r;
    for (int i = 0; i < LANES; i++) r[i*9 +: 9] = model_tap[i];
    return r;
  endfunction

  // Closed-form expectation from the command rules.
  function automatic exp_t model(input int lane, input int op, input int arg, input int start);
    exp_t e;
    int room, k;
    e.done_c = 1; e.n_ce = 0; e.n_ld = 0; e.sat = 1'b0; e.err = 1'b0; e.drop = 1'b0; e.tap = start;
    if (lane >= LANES || op == 3) begin
      e.err = 1'b1;
    end else if (op == 2) begin
      e.drop = 1'b1; e.n_ld = 1; e.sat = (arg > MAXT);
      e.tap = (arg > MAXT) ? MAXT : arg;
      e.done_c = 1 + VS + SS + 1;
    end else if (arg != 0) begin
      room = (op == 0) ? (MAXT - start) : start;
      k = (arg < room) ? arg : room;
      e.sat = (k < arg); e.drop = 1'b1; e.n_ce = k;
      e.tap = (op == 0) ? (start + k) : (start - k);
      e.done_c = 1 + VS + k * (SS + 1);
    end
    return e;
  endfunction

  function automatic bit ce_slot(input int c, input int n);
    if (c < 1 + VS) return 1'b0;
    return ((c - 1 - VS) % (SS + 1) == 0) && ((c - 1 - VS) / (SS + 1) < n);
  endfunction

  task automatic run_cmd(input string tag, input int lane, input int op, input int arg,
                         input int abort_c, input exp_t e);
    int c, w, done_c, n_ce, n_ld, tbad, vbad;
    logic sat, err;
    logic [3:0] exp_vtc;
    logic [8:0] e_cnt;
    e_cnt = 9'((arg > MAXT) ? MAXT : arg);
    done_c = -1; n_ce = 0; n_ld = 0; tbad = 0; vbad = 0; sat = 1'b0; err = 1'b0;
    cmd_lane = 2'(lane); cmd_op = 2'(op); cmd_arg = 9'(arg); cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, ".accept_ready"}, 64'(cmd_ready), 64'd1);
    @(posedge clk);
    c = 0;
    while (done_c < 0 && c < 3000) begin
      c++;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < LANES; i++) begin
        if (ce[i]) begin
          if (i != lane || !ce_slot(c, e.n_ce) || inc !== (op == 0)) tbad++;
          if (i == lane) n_ce++;
        end
        if (load[i]) begin
          if (i != lane || c != 1 + VS || cntv !== e_cnt) tbad++;
          n_ld++;
        end
      end
      if ((ce & load) != 4'd0) tbad++;
      exp_vtc = '1;
      if (e.drop && c < e.done_c) exp_vtc[lane] = 1'b0;
      if (en_vtc !== exp_vtc) vbad++;
      if (done) begin
        done_c = c; sat = done_sat; err = done_err;
      end
      if (c == abort_c) idelay_rdy = 1'b0;
    end
    idelay_rdy = 1'b1;
    check({tag, ".done_cycle"}, 64'(done_c), 64'(e.done_c));
    check({tag, ".ce_count"},   64'(n_ce),   64'(e.n_ce));
    check({tag, ".load_count"}, 64'(n_ld),   64'(e.n_ld));
    check({tag, ".done_sat"},   64'(sat),    64'(e.sat));
    check({tag, ".done_err"},   64'(err),    64'(e.err));
    check({tag, ".pulse_timing_errs"}, 64'(tbad), 64'd0);
    check({tag, ".en_vtc_errs"}, 64'(vbad), 64'd0);
    @(negedge clk);
    check({tag, ".done_then_idle"}, 64'({done, busy}), 64'd0);
    if (e.drop) model_tap[lane] = 9'(e.tap);
    check({tag, ".tap_value"}, 64'(tapv), 64'(pack_model()));
  endtask

  vec_t vt [12];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int cnt, seen_cv, seen_done;
    logic s2, e2;

    vt[0]  = '{2, 0,   3,  26,  3, 0, 1'b0, 1'b0,  28};
    vt[1]  = '{0, 1,  40, 136, 25, 0, 1'b1, 1'b0,   0};
    vt[2]  = '{1, 2, 100,  16,  0, 1, 1'b0, 1'b0, 100};
    vt[3]  = '{3, 2, 511,  16,  0, 1, 1'b0, 1'b0, 511};
    vt[4]  = '{3, 0,   5,  11,  0, 0, 1'b1, 1'b0, 511};
    vt[5]  = '{1, 0,   0,   1,  0, 0, 1'b0, 1'b0, 100};
    vt[6]  = '{2, 3,   7,   1,  0, 0, 1'b0, 1'b1,  28};
    vt[7]  = '{2, 1,   3,  26,  3, 0, 1'b0, 1'b0,  25};
    vt[8]  = '{0, 2,   0,  16,  0, 1, 1'b0, 1'b0,   0};
    vt[9]  = '{0, 1,   1,  11,  0, 0, 1'b1, 1'b0,   0};
    vt[10] = '{3, 1,   2,  21,  2, 0, 1'b0, 1'b0, 509};
    vt[11] = '{1, 1,   0,   1,  0, 0, 1'b0, 1'b0, 100};

    rst_n = 1'b0; idelay_rdy = 1'b1; cmd_valid = 1'b0; cmd_lane = '0; cmd_op = '0; cmd_arg = '0;
    d2_rdy = 1'b1; d2_valid = 1'b0; d2_lane = '0; d2_op = '0; d2_arg = '0;
    for (int i = 0; i < LANES; i++) model_tap[i] = 9'(DEFT);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("reset.en_vtc",   64'(en_vtc), 64'hF);
    check("reset.tap_value", 64'(tapv),  64'(pack_model()));
    check("reset.pulses",   64'({ce, load, inc, done, done_sat, done_err}), 64'd0);
    check("reset.busy",     64'(busy), 64'd0);
    check("reset.cntvalue", 64'(cntv), 64'd0);
    idelay_rdy = 1'b0; #1;
    check("reset.ready_low", 64'(cmd_ready), 64'd0);
    idelay_rdy = 1'b1; #1;
    check("reset.ready_high", 64'(cmd_ready), 64'd1);

    for (int t = 0; t < 12; t++) begin
      e.done_c = vt[t].done_c; e.n_ce = vt[t].n_ce; e.n_ld = vt[t].n_ld;
      e.sat = vt[t].sat; e.err = vt[t].err; e.tap = vt[t].tap;
      e.drop = (vt[t].op != 3) && !(vt[t].op != 2 && vt[t].arg == 0);
      run_cmd($sformatf("tbl%0d", t), vt[t].lane, vt[t].op, vt[t].arg, 0, e);
    end

    // Ready drops one cycle after the second CE of a 5-step INC.
    e.done_c = 18; e.n_ce = 2; e.n_ld = 0; e.sat = 1'b0; e.err = 1'b1; e.drop = 1'b1;
    e.tap = int'(model_tap[2]) + 2;
    run_cmd("abort", 2, 0, 5, 17, e);

    for (int r = 0; r < 14; r++) begin
      int lane, op, arg, sel;
      lane = $urandom_range(0, 3);
      sel  = $urandom_range(0, 9);
      op   = (sel < 4) ? 0 : (sel < 8) ? 1 : (sel == 8) ? 2 : 3;
      if (op == 2)                     arg = $urandom_range(0, 511);
      else if ($urandom_range(0, 3) == 0) arg = $urandom_range(0, 40);
      else                             arg = $urandom_range(0, 6);
      e = model(lane, op, arg, int'(model_tap[lane]));
      run_cmd($sformatf("rnd%0d", r), lane, op, arg, 0, e);
    end

    cmd_lane = 2'd1; cmd_op = 2'd0; cmd_arg = 9'd5; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < LANES; i++) model_tap[i] = 9'(DEFT);
    check("midrst.en_vtc",   64'(en_vtc), 64'hF);
    check("midrst.pulses",   64'({ce, load, inc, done, done_sat, done_err}), 64'd0);
    check("midrst.busy",     64'(busy), 64'd0);
    check("midrst.cntvalue", 64'(cntv), 64'd0);
    check("midrst.tap_value", 64'(tapv), 64'(pack_model()));
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("midrst.no_done", 64'(cnt), 64'd0);

    d2_lane = 2'd3; d2_op = 2'd0; d2_arg = 9'd5; d2_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d2_valid = 1'b0;
    check("lane_rej.done",  64'({d2_done, d2_err, d2_sat}), 64'b110);
    check("lane_rej.quiet", 64'({d2_vtc, d2_ce, d2_load}), 64'b111_000_000);
    @(negedge clk);

    d2_lane = 2'd0; d2_op = 2'd2; d2_arg = 9'd400; d2_valid = 1'b1;
    @(posedge clk);
    seen_cv = -1; seen_done = 0; s2 = 1'b0; e2 = 1'b0; cnt = 0;
    while (!seen_done && cnt < 100) begin
      cnt++;
      @(negedge clk);
      d2_valid = 1'b0;
      if (d2_load[0]) seen_cv = int'(d2_cntv);
      if (d2_done) begin
        seen_done = 1; s2 = d2_sat; e2 = d2_err;
      end
    end
    check("load_clip.done_seen", 64'(seen_done), 64'd1);
    check("load_clip.cntvalue",  64'(seen_cv), 64'd300);
    check("load_clip.flags",     64'({s2, e2}), 64'b10);
    check("load_clip.tap_value", 64'(d2_tapv), 64'({9'd25, 9'd25, 9'd300}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
